// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IFU/LSU memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  localparam logic [3:0] LEN_B = 4'd1;
  localparam logic [3:0] LEN_H = 4'd2;
  localparam logic [3:0] LEN_W = 4'd4;
  localparam logic [3:0] LEN_D = 4'd8;

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way priority picker: LSU wins unless the IFU has been passed over
// starve_lim_i times in a row.
module mem_arb_pick (
  input  logic       en_i,
  input  logic       ifu_req_i,
  input  logic       lsu_req_i,
  input  logic [3:0] streak_i,
  input  logic [3:0] starve_lim_i,
  output logic       gnt_ifu_o,
  output logic       gnt_lsu_o
);

  logic ifu_wins;

  assign ifu_wins  = ifu_req_i & (~lsu_req_i | (streak_i == starve_lim_i));
  assign gnt_ifu_o = en_i & ifu_wins;
  assign gnt_lsu_o = en_i & lsu_req_i & ~ifu_wins;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one
// transaction outstanding at a time, with fetch squash on redirect.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              ifu_req,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_gnt,
  input  logic              ifu_flush,
  output logic              ifu_rvalid,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_req,
  input  logic              lsu_wen,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [3:0]        lsu_wlen,
  output logic              lsu_gnt,
  output logic              lsu_rvalid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wlen,
  output logic              mem_wen,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] LIM = 4'(STARVE_LIM);

  state_e            state_q;
  owner_e            owner_q;
  logic [3:0]        streak_q;
  logic              drop_q;
  logic              mem_req_valid_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [3:0]        mem_wlen_q;
  logic              mem_wen_q;
  logic              ifu_rvalid_q;
  logic              lsu_rvalid_q;
  logic [DATA_W-1:0] ifu_rdata_q;
  logic [DATA_W-1:0] lsu_rdata_q;
  logic              pick_ifu;
  logic              pick_lsu;

  mem_arb_pick u_pick (
    .en_i         (state_q == IDLE),
    .ifu_req_i    (ifu_req),
    .lsu_req_i    (lsu_req),
    .streak_i     (streak_q),
    .starve_lim_i (LIM),
    .gnt_ifu_o    (pick_ifu),
    .gnt_lsu_o    (pick_lsu)
  );

  // Grants are masked while reset is held so no requester sees an acceptance
  // that was never latched.
  assign ifu_gnt       = pick_ifu & rstn;
  assign lsu_gnt       = pick_lsu & rstn;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wlen      = mem_wlen_q;
  assign mem_wen       = mem_wen_q;
  assign ifu_rvalid    = ifu_rvalid_q;
  assign ifu_rdata     = ifu_rdata_q;
  assign lsu_rvalid    = lsu_rvalid_q;
  assign lsu_rdata     = lsu_rdata_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= IDLE;
      owner_q         <= OWN_IFU;
      streak_q        <= '0;
      drop_q          <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      mem_wlen_q      <= '0;
      mem_wen_q       <= 1'b0;
      ifu_rvalid_q    <= 1'b0;
      lsu_rvalid_q    <= 1'b0;
      ifu_rdata_q     <= '0;
      lsu_rdata_q     <= '0;
    end else begin
      ifu_rvalid_q <= 1'b0;
      lsu_rvalid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          drop_q <= 1'b0;
          if (pick_ifu) begin
            owner_q         <= OWN_IFU;
            mem_addr_q      <= ifu_addr;
            mem_wdata_q     <= '0;
            mem_wlen_q      <= LEN_D;
            mem_wen_q       <= 1'b0;
            streak_q        <= '0;
            drop_q          <= ifu_flush;
            mem_req_valid_q <= 1'b1;
            state_q         <= REQ;
          end else if (pick_lsu) begin
            owner_q         <= OWN_LSU;
            mem_addr_q      <= lsu_addr;
            mem_wdata_q     <= lsu_wdata;
            mem_wlen_q      <= lsu_wlen;
            mem_wen_q       <= lsu_wen;
            streak_q        <= ifu_req ? streak_q + 4'd1 : 4'd0;
            mem_req_valid_q <= 1'b1;
            state_q         <= REQ;
          end
        end
        REQ: begin
          if (owner_q == OWN_IFU && ifu_flush) drop_q <= 1'b1;
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= WAIT;
          end
        end
        WAIT: begin
          if (owner_q == OWN_IFU && ifu_flush) drop_q <= 1'b1;
          if (mem_resp_valid) begin
            if (owner_q == OWN_LSU) begin
              lsu_rvalid_q <= 1'b1;
              lsu_rdata_q  <= mem_wen_q ? '0 : mem_rdata;
            end else if (!(drop_q || ifu_flush)) begin
              // a flush arriving with the response still squashes it
              ifu_rvalid_q <= 1'b1;
              ifu_rdata_q  <= mem_rdata;
            end
            drop_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: per-port expected-data queues filled by the
// request drivers, a grant-ordered payload queue checked by the memory model.
`timescale 1ns/1ps
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ifu_req = 1'b0, ifu_flush = 1'b0, ifu_gnt, ifu_rvalid;
  logic [63:0] ifu_addr = '0, ifu_rdata;
  logic        lsu_req = 1'b0, lsu_wen = 1'b0, lsu_gnt, lsu_rvalid;
  logic [63:0] lsu_addr = '0, lsu_wdata = '0, lsu_rdata;
  logic [3:0]  lsu_wlen = '0;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wlen;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_LIM(4)) dut (
    .clk(clk), .rstn(rstn),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_gnt(ifu_gnt), .ifu_flush(ifu_flush),
    .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
    .lsu_req(lsu_req), .lsu_wen(lsu_wen), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_wlen(lsu_wlen), .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wlen(mem_wlen), .mem_wen(mem_wen),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [3:0]  wlen;
    logic        wen;
    logic        own_lsu;
  } pay_t;

  int          n_chk = 0, n_fail = 0, cyc = 0;
  logic [63:0] ifu_exp[$], lsu_exp[$];
  pay_t        pay_q[$];
  byte         glog[$];
  int          ifu_gnt_cyc, lsu_gnt_cyc, ifu_rv_cyc, lsu_rv_cyc, mreq_cyc;
  int          ifu_rv_cnt = 0, lsu_rv_cnt = 0;
  int          ready_dly = 0, resp_dly = 0, rdy_cnt = 0, lat_cnt = 0, resp_cnt = 0;
  bit          pend = 0, inject_late = 0, prev_mrv = 0;
  logic [63:0] paddr;
  pay_t        p;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mdata(input logic [63:0] a);
    if (a == 64'h8000_0000) return 64'h0010_0093;
    return {a[31:0] ^ 32'h5A5A_5A5A, ~a[31:0]};
  endfunction

  // Monitor: samples 2 ns before each rising edge.
  initial forever begin
    @(negedge clk); #3;
    if (rstn) begin
      if (ifu_gnt || lsu_gnt) check("gnt_exclusive", ifu_gnt & lsu_gnt, 1'b0);
      if (ifu_gnt) begin
        glog.push_back("I");
        ifu_gnt_cyc = cyc;
        pay_q.push_back('{ifu_addr, 64'h0, LEN_D, 1'b0, 1'b0});
      end
      if (lsu_gnt) begin
        glog.push_back("L");
        lsu_gnt_cyc = cyc;
        pay_q.push_back('{lsu_addr, lsu_wdata, lsu_wlen, lsu_wen, 1'b1});
      end
      if (mem_req_valid && !prev_mrv) mreq_cyc = cyc;
      prev_mrv = mem_req_valid;
      if (ifu_rvalid) begin
        ifu_rv_cnt++;
        ifu_rv_cyc = cyc;
        check("ifu_rvalid_expected", ifu_exp.size() != 0, 1'b1);
        if (ifu_exp.size() != 0) check("ifu_rdata", ifu_rdata, ifu_exp.pop_front());
      end
      if (lsu_rvalid) begin
        lsu_rv_cnt++;
        lsu_rv_cyc = cyc;
        check("lsu_rvalid_expected", lsu_exp.size() != 0, 1'b1);
        if (lsu_exp.size() != 0) check("lsu_rdata", lsu_rdata, lsu_exp.pop_front());
      end
    end else begin
      prev_mrv = 0;
    end
  end

  // Memory model: ready after ready_dly REQ cycles, response resp_dly cycles into WAIT.
  initial begin
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b0;
      if (!rstn) begin
        pend = 0; rdy_cnt = 0;
      end else if (inject_late) begin
        mem_resp_valid = 1'b1;
        mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        inject_late = 0;
      end else if (pend) begin
        if (lat_cnt == 0) begin
          mem_resp_valid = 1'b1;
          mem_rdata = mdata(paddr);
          pend = 0;
          resp_cnt++;
        end else lat_cnt--;
      end else if (mem_req_valid) begin
        check("mem_req_has_grant", pay_q.size() != 0, 1'b1);
        if (pay_q.size() != 0) begin
          p = pay_q[0];
          check("mem_addr", mem_addr, p.addr);
          check("mem_wen", mem_wen, p.wen);
          if (p.own_lsu) begin
            check("mem_wdata", mem_wdata, p.wdata);
            check("mem_wlen", mem_wlen, p.wlen);
          end
          if (rdy_cnt == ready_dly) begin
            mem_req_ready = 1'b1;
            rdy_cnt = 0; pend = 1; lat_cnt = resp_dly; paddr = p.addr;
            void'(pay_q.pop_front());
          end else rdy_cnt++;
        end
      end
    end
  end

  // Drivers are called at a falling edge and return at a falling edge.
  task automatic ifu_fetch(input logic [63:0] a, input bit want, input bit flush_gnt);
    bit got = 0;
    ifu_req = 1'b1; ifu_addr = a; ifu_flush = flush_gnt;
    if (want) ifu_exp.push_back(mdata(a));
    for (int i = 0; i < 200; i++) begin
      #3; got = ifu_gnt;
      @(negedge clk);
      if (got) break;
    end
    ifu_req = 1'b0; ifu_flush = 1'b0;
    check("ifu_gnt_seen", got, 1'b1);
  endtask

  task automatic lsu_access(input logic wen, input logic [63:0] a, input logic [63:0] d,
                            input logic [3:0] len);
    bit got = 0;
    lsu_req = 1'b1; lsu_wen = wen; lsu_addr = a; lsu_wdata = d; lsu_wlen = len;
    lsu_exp.push_back(wen ? 64'h0 : mdata(a));
    for (int i = 0; i < 200; i++) begin
      #3; got = lsu_gnt;
      @(negedge clk);
      if (got) break;
    end
    lsu_req = 1'b0;
    check("lsu_gnt_seen", got, 1'b1);
  endtask

  task automatic drain(input int maxc);
    bit done = 0;
    for (int i = 0; i < maxc; i++) begin
      if (ifu_exp.size() == 0 && lsu_exp.size() == 0 && !pend && !mem_req_valid) begin
        done = 1;
        break;
      end
      @(negedge clk);
    end
    check("drain", done, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic outs_zero(input string tag);
    check({tag, "_gnt"}, {ifu_gnt, lsu_gnt}, 2'b00);
    check({tag, "_rvalid"}, {ifu_rvalid, lsu_rvalid, mem_req_valid}, 3'b000);
    check({tag, "_mem_addr"}, mem_addr, 64'h0);
    check({tag, "_mem_wdata"}, mem_wdata, 64'h0);
    check({tag, "_mem_wlen_wen"}, {mem_wlen, mem_wen}, 5'h0);
    check({tag, "_ifu_rdata"}, ifu_rdata, 64'h0);
    check({tag, "_lsu_rdata"}, lsu_rdata, 64'h0);
  endtask

  int   rv0, resp0;
  byte  exp_ord[7];

  initial begin
    #12;
    outs_zero("reset");
    @(negedge clk); rstn = 1'b1;
    @(negedge clk);

    // 1: single fetch, response one cycle into WAIT
    ready_dly = 0; resp_dly = 1;
    ifu_fetch(64'h8000_0000, 1, 0);
    drain(50);
    check("t1_req_latency", mreq_cyc - ifu_gnt_cyc, 1);
    check("t1_rvalid_latency", ifu_rv_cyc - ifu_gnt_cyc, 4);

    // 2: contention, LSU first, IFU at the next IDLE
    resp_dly = 0;
    glog.delete();
    fork
      ifu_fetch(64'h8000_0040, 1, 0);
      lsu_access(1'b0, 64'h8000_2000, 64'h0, LEN_W);
    join
    drain(50);
    check("t2_order_n", glog.size(), 2);
    if (glog.size() == 2) begin
      check("t2_first", glog[0], "L");
      check("t2_second", glog[1], "I");
    end
    check("t2_lsu_latency", lsu_rv_cyc - lsu_gnt_cyc, 3);
    check("t2_ifu_after_lsu", ifu_gnt_cyc - lsu_gnt_cyc, 3);

    // 3: starvation bound with back-to-back stores
    glog.delete();
    exp_ord = '{"L", "L", "L", "L", "I", "L", "L"};
    fork
      ifu_fetch(64'h8000_0080, 1, 0);
      for (int k = 0; k < 6; k++)
        lsu_access(1'b1, 64'h8000_3000 + 64'(8 * k), 64'h1111_0000 + 64'(k), LEN_D);
    join
    drain(100);
    check("t3_order_n", glog.size(), 7);
    for (int k = 0; k < 7 && k < glog.size(); k++) check("t3_order", glog[k], exp_ord[k]);

    // 4: flush in WAIT, flush with grant, flush ignored for LSU
    resp_dly = 2;
    rv0 = ifu_rv_cnt; resp0 = resp_cnt;
    ifu_fetch(64'h8000_00C0, 0, 0);
    @(negedge clk); ifu_flush = 1'b1;
    @(negedge clk); ifu_flush = 1'b0;
    drain(50);
    check("t4_bus_completed", resp_cnt - resp0, 1);
    check("t4_squashed", ifu_rv_cnt - rv0, 0);
    ifu_fetch(64'h8000_0100, 0, 1);
    drain(50);
    check("t4_gnt_flush_squashed", ifu_rv_cnt - rv0, 0);
    ifu_fetch(64'h8000_0140, 1, 0);
    drain(50);
    check("t4_next_fetch", ifu_rv_cnt - rv0, 1);
    rv0 = lsu_rv_cnt;
    lsu_access(1'b0, 64'h8000_4000, 64'h0, LEN_H);
    @(negedge clk); ifu_flush = 1'b1;
    @(negedge clk); ifu_flush = 1'b0;
    drain(50);
    check("t4_lsu_unaffected", lsu_rv_cnt - rv0, 1);

    // 5: store with backpressure
    ready_dly = 3; resp_dly = 0;
    lsu_access(1'b1, 64'h8000_1000, 64'hDEAD_BEEF, LEN_D);
    drain(50);
    check("t5_latency", lsu_rv_cyc - lsu_gnt_cyc, 6);

    // 6: reset mid-WAIT, then a stray response
    ready_dly = 0; resp_dly = 6;
    rv0 = ifu_rv_cnt;
    ifu_fetch(64'h8000_0180, 0, 0);
    repeat (2) @(negedge clk);
    #2 rstn = 1'b0;
    #1 outs_zero("midreset");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk); #1 inject_late = 1;
    repeat (4) @(negedge clk);
    check("t6_no_rvalid", ifu_rv_cnt - rv0, 0);
    check("t6_inject_consumed", inject_late, 1'b0);
    resp_dly = 0;
    ifu_fetch(64'h8000_01C0, 1, 0);
    drain(50);
    check("t6_recovered", ifu_rv_cnt - rv0, 1);
    check("end_pay_q_empty", pay_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
